cache_port_arbiter: RTL and testbench
=====================================

// Module: cache_port_arbiter
// PURPOSE
//  Two-master round-robin arbiter/sequencer in front of the single data_cache port.
//  Latches one master's request and drives the cache en/r0w1/addr/din for that request.
//  Holds the request until the cache raises rdy, then returns dout to the granted master.
//  Sits between the pipeline memory stage (m0) and a secondary requester (m1, e.g. DMA/debug).
// PARAMETERS
//  AW       32   address width
//  DW       32   data width
//  TIMEOUT  255  max BUSY cycles without c_rdy before abort (used only with the _EN macro)
// PORTS
//  clk       in   1   clock, rising edge
//  rst       in   1   synchronous reset, active-low
//  m0_req    in   1   master 0 request, level; held until m0_done
//  m0_r0w1   in   1   master 0 op: 0 read, 1 write
//  m0_addr   in   AW  master 0 address
//  m0_din    in   DW  master 0 write data
//  m0_done   out  1   1-cycle completion pulse to master 0
//  m0_dout   out  DW  read data; valid while m0_done=1
//  m1_*      —    —   same six signals for master 1
//  c_en      out  1   cache enable
//  c_r0w1    out  1   cache op
//  c_addr    out  AW  cache address
//  c_din     out  DW  cache write data
//  c_rdy     in   1   cache completion, sampled only while c_en=1
//  c_dout    in   DW  cache read data, valid with c_rdy
//  arb_err   out  1   1-cycle timeout pulse; tied 0 without macro
//  busy      out  1   1 when state != IDLE
// BEHAVIOUR
//  - Reset (rst=0 at an edge): state=IDLE, last_gnt=1 (m0 wins first tie), all outputs 0.
//  - FSM IDLE -> BUSY -> DONE -> IDLE.
//  - IDLE: if any mX_req=1, grant. Both requesting: grant the master != last_gnt.
//    Latch r0w1/addr/din of the winner into regs; next state BUSY.
//  - BUSY: c_en=1; c_r0w1/c_addr/c_din driven from the latched regs only.
//    Master input changes or req drop during BUSY are ignored; the transaction completes.
//    c_rdy=1: capture c_dout into a data reg; next state DONE. c_en is 0 from the next cycle.
//  - DONE: mX_done=1 for the granted master only. mX_dout = captured data; 0 for a write.
//    The other master's done and dout = 0. last_gnt <= granted master; next state IDLE.
//  - Master drops req in the cycle after sampling done; a req still high in IDLE is a new request.
//  - Latency: req at cycle 0 -> c_en at 1 -> c_rdy at k>=1 -> done at k+1.
//    Minimum 3 cycles req-to-done; c_en low for >=2 cycles between back-to-back transactions.
//  - One outstanding transaction only; no bypass of IDLE.
//  - Reset asserted in any state: IDLE next edge, c_en=0, in-flight op dropped, no done/err pulse.
//  - c_rdy while c_en=0 is ignored.
// CONFIGURATION
//  CACHE_ARB_TIMEOUT_EN defined:
//    - Counter cleared on entry to BUSY; +1 per BUSY cycle with c_rdy=0.
//    - Count reaching TIMEOUT: next state DONE, captured data=0.
//    - In DONE, mX_done and arb_err pulse together.
//    - Counter width $clog2(TIMEOUT+1).
//  Undefined: BUSY waits for c_rdy indefinitely; arb_err=0; no counter logic.
// TESTING
//  1 rst=0 for 2 cycles with both reqs high -> all outputs 0, busy=0; release -> m0 granted first.
//  2 m0 read 0x00000004; c_rdy at 3rd BUSY cycle, c_dout=0x5a5a5a5a
//    -> c_addr=0x4, c_r0w1=0; one m0_done with m0_dout=0x5a5a5a5a; m1_done stays 0.
//  3 Same cycle: m0 write 0x4 din 0x5a5a5a5a, m1 read 0x84
//    -> m0 write served, then m1 read (c_addr=0x84); c_en low for 2 cycles between.
//  4 m0_req held high throughout, m1_req raised -> grants alternate m0,m1,m0,m1; no starvation.
//  5 rst=0 during BUSY, then c_rdy=1 -> c_en=0 after the edge; no done pulse; next req restarts cleanly.
//  6 Macro on, TIMEOUT=8, c_rdy held 0 on m1 read
//    -> after 8 BUSY cycles, m1_done and arb_err pulse once, m1_dout=0, back to IDLE.

Source files
------------

// File: rtl/cache_port_arbiter.sv
// Two-master round-robin arbiter/sequencer in front of the single data cache port.
// Grants one master, drives the cache from latched request fields, waits for c_rdy,
// then returns a one-cycle done pulse (plus read data) to the granted master.
// Optional macro CACHE_ARB_TIMEOUT_EN adds a BUSY watchdog that aborts the
// transaction after TIMEOUT cycles without c_rdy and pulses arb_err.
module cache_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_r0w1,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_din,
  output logic          m0_done,
  output logic [DW-1:0] m0_dout,
  input  logic          m1_req,
  input  logic          m1_r0w1,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_din,
  output logic          m1_done,
  output logic [DW-1:0] m1_dout,
  output logic          c_en,
  output logic          c_r0w1,
  output logic [AW-1:0] c_addr,
  output logic [DW-1:0] c_din,
  input  logic          c_rdy,
  input  logic [DW-1:0] c_dout,
  output logic          arb_err,
  output logic          busy
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic            last_gnt_q, last_gnt_d;  // 0: m0, 1: m1
  logic            gnt_q, gnt_d;
  logic            r0w1_q, r0w1_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   din_q, din_d;
  logic [DW-1:0]   data_d;
  logic            c_en_q, c_en_d;
  logic            busy_q, busy_d;
  logic            m0_done_q, m0_done_d;
  logic            m1_done_q, m1_done_d;
  logic [DW-1:0]   m0_dout_q, m0_dout_d;
  logic [DW-1:0]   m1_dout_q, m1_dout_d;
  logic            arb_err_q, arb_err_d;
  logic            timeout;

`ifdef CACHE_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] cnt_q, cnt_d;

  // Watchdog: fires on the BUSY cycle whose increment would reach TIMEOUT.
  always_comb begin
    cnt_d   = cnt_q;
    timeout = 1'b0;
    if (state_q == StIdle) begin
      cnt_d = '0;
    end else if (state_q == StBusy && !c_rdy) begin
      cnt_d   = cnt_q + 1'b1;
      timeout = (cnt_q == CntW'(TIMEOUT - 1));
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign timeout        = 1'b0;
`endif

  // Next-state: grant/latch in IDLE, wait for completion in BUSY, pulse in DONE.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    gnt_d      = gnt_q;
    r0w1_d     = r0w1_q;
    addr_d     = addr_q;
    din_d      = din_q;
    data_d     = '0;
    unique case (state_q)
      StIdle: begin
        if (m0_req || m1_req) begin
          gnt_d   = (m0_req && m1_req) ? ~last_gnt_q : m1_req;
          r0w1_d  = gnt_d ? m1_r0w1 : m0_r0w1;
          addr_d  = gnt_d ? m1_addr : m0_addr;
          din_d   = gnt_d ? m1_din  : m0_din;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (c_rdy) begin
          data_d  = r0w1_q ? '0 : c_dout;
          state_d = StDone;
        end else if (timeout) begin
          state_d = StDone;
        end
      end
      StDone: begin
        last_gnt_d = gnt_q;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered outputs derived from the upcoming state.
  always_comb begin
    c_en_d    = (state_d == StBusy);
    busy_d    = (state_d != StIdle);
    m0_done_d = (state_d == StDone) && !gnt_d;
    m1_done_d = (state_d == StDone) && gnt_d;
    m0_dout_d = m0_done_d ? data_d : '0;
    m1_dout_d = m1_done_d ? data_d : '0;
    arb_err_d = (state_d == StDone) && timeout;
  end

  // State and output registers; reset drops any in-flight transaction silently.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      last_gnt_q <= 1'b1;
      gnt_q      <= 1'b0;
      r0w1_q     <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      c_en_q     <= 1'b0;
      busy_q     <= 1'b0;
      m0_done_q  <= 1'b0;
      m1_done_q  <= 1'b0;
      m0_dout_q  <= '0;
      m1_dout_q  <= '0;
      arb_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
      r0w1_q     <= r0w1_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      c_en_q     <= c_en_d;
      busy_q     <= busy_d;
      m0_done_q  <= m0_done_d;
      m1_done_q  <= m1_done_d;
      m0_dout_q  <= m0_dout_d;
      m1_dout_q  <= m1_dout_d;
      arb_err_q  <= arb_err_d;
    end
  end

  assign c_en    = c_en_q;
  assign c_r0w1  = r0w1_q;
  assign c_addr  = addr_q;
  assign c_din   = din_q;
  assign busy    = busy_q;
  assign m0_done = m0_done_q;
  assign m1_done = m1_done_q;
  assign m0_dout = m0_dout_q;
  assign m1_dout = m1_dout_q;
  assign arb_err = arb_err_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed self-checking bench for cache_port_arbiter.
module tb_cache_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
`ifdef CACHE_ARB_TIMEOUT_EN
  localparam int unsigned TIMEOUT = 8;
`else
  localparam int unsigned TIMEOUT = 255;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_r0w1, m1_req, m1_r0w1;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_din, m1_din;
  logic          m0_done, m1_done;
  logic [DW-1:0] m0_dout, m1_dout;
  logic          c_en, c_r0w1, c_rdy;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_din, c_dout;
  logic          arb_err, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_r0w1(m0_r0w1), .m0_addr(m0_addr), .m0_din(m0_din),
    .m0_done(m0_done), .m0_dout(m0_dout),
    .m1_req(m1_req), .m1_r0w1(m1_r0w1), .m1_addr(m1_addr), .m1_din(m1_din),
    .m1_done(m1_done), .m1_dout(m1_dout),
    .c_en(c_en), .c_r0w1(c_r0w1), .c_addr(c_addr), .c_din(c_din),
    .c_rdy(c_rdy), .c_dout(c_dout), .arb_err(arb_err), .busy(busy)
  );

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0; m0_req = 1'b0; m1_req = 1'b0; c_rdy = 1'b0; c_dout = '0;
    m0_r0w1 = 1'b0; m1_r0w1 = 1'b0; m0_addr = '0; m1_addr = '0; m0_din = '0; m1_din = '0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; c_rdy = 1'b0; c_dout = '0;
    m0_req = 1'b1; m0_r0w1 = 1'b0; m0_addr = 32'h10; m0_din = 32'haaaa_0000;
    m1_req = 1'b1; m1_r0w1 = 1'b0; m1_addr = 32'h20; m1_din = 32'hbbbb_0000;
    tick();
    tick();
    checks++; if (c_en !== 1'b0)   begin errors++; $display("FAIL rst_c_en got %b want 0", c_en); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (m0_done !== 1'b0 || m1_done !== 1'b0)
      begin errors++; $display("FAIL rst_done got %b%b want 00", m0_done, m1_done); end
    checks++; if (arb_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", arb_err); end
    checks++; if (c_addr !== 32'h0 || m0_dout !== 32'h0 || m1_dout !== 32'h0)
      begin errors++; $display("FAIL rst_data got %h/%h/%h want 0", c_addr, m0_dout, m1_dout); end
    rst = 1'b1;
    tick();
    checks++; if (c_en !== 1'b1 || c_addr !== 32'h10)
      begin errors++; $display("FAIL rst_first_gnt got en=%b addr=%h want 1/10", c_en, c_addr); end
    c_rdy = 1'b1; c_dout = 32'h0000_0011;
    tick();
    c_rdy = 1'b0;
    checks++; if (m0_done !== 1'b1 || m0_dout !== 32'h11 || m1_done !== 1'b0)
      begin errors++; $display("FAIL rst_first_done got %b/%h/%b want 1/11/0", m0_done, m0_dout, m1_done); end
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle got %b want 0", busy); end
  endtask

  task automatic test_read();
    apply_reset();
    m0_req = 1'b1; m0_r0w1 = 1'b0; m0_addr = 32'h4;
    tick();
    checks++; if (c_en !== 1'b1 || c_addr !== 32'h4 || c_r0w1 !== 1'b0)
      begin errors++; $display("FAIL rd_issue got en=%b addr=%h op=%b want 1/4/0", c_en, c_addr, c_r0w1); end
    m0_addr = 32'h99; m0_r0w1 = 1'b1; // must not leak into the latched request
    c_rdy = 1'b0;
    tick();
    checks++; if (c_addr !== 32'h4 || c_r0w1 !== 1'b0 || m0_done !== 1'b0)
      begin errors++; $display("FAIL rd_hold got addr=%h op=%b done=%b want 4/0/0", c_addr, c_r0w1, m0_done); end
    tick();
    c_rdy = 1'b1; c_dout = 32'h5a5a_5a5a;
    tick();
    c_rdy = 1'b0; c_dout = '0;
    checks++; if (m0_done !== 1'b1 || m0_dout !== 32'h5a5a_5a5a || m1_done !== 1'b0 || c_en !== 1'b0)
      begin errors++; $display("FAIL rd_done got %b/%h/%b/%b want 1/5a5a5a5a/0/0",
                               m0_done, m0_dout, m1_done, c_en); end
    m0_req = 1'b0;
    tick();
    checks++; if (m0_done !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL rd_single_pulse got done=%b busy=%b want 0/0", m0_done, busy); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    m0_req = 1'b1; m0_r0w1 = 1'b1; m0_addr = 32'h4;  m0_din = 32'h5a5a_5a5a;
    m1_req = 1'b1; m1_r0w1 = 1'b0; m1_addr = 32'h84; m1_din = 32'h0;
    tick();
    checks++; if (c_en !== 1'b1 || c_r0w1 !== 1'b1 || c_addr !== 32'h4 || c_din !== 32'h5a5a_5a5a)
      begin errors++; $display("FAIL b2b_wr got en=%b op=%b addr=%h din=%h want 1/1/4/5a5a5a5a",
                               c_en, c_r0w1, c_addr, c_din); end
    c_rdy = 1'b1; c_dout = 32'hdead_beef;
    tick();
    c_rdy = 1'b0;
    checks++; if (m0_done !== 1'b1 || m0_dout !== 32'h0 || m1_done !== 1'b0 || c_en !== 1'b0)
      begin errors++; $display("FAIL b2b_wr_done got %b/%h/%b/%b want 1/0/0/0",
                               m0_done, m0_dout, m1_done, c_en); end
    m0_req = 1'b0;
    tick();
    checks++; if (c_en !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL b2b_gap got en=%b busy=%b want 0/0", c_en, busy); end
    tick();
    checks++; if (c_en !== 1'b1 || c_addr !== 32'h84 || c_r0w1 !== 1'b0)
      begin errors++; $display("FAIL b2b_rd got en=%b addr=%h op=%b want 1/84/0", c_en, c_addr, c_r0w1); end
    c_rdy = 1'b1; c_dout = 32'h1234_5678;
    tick();
    c_rdy = 1'b0;
    checks++; if (m1_done !== 1'b1 || m1_dout !== 32'h1234_5678 || m0_done !== 1'b0 || m0_dout !== 32'h0)
      begin errors++; $display("FAIL b2b_rd_done got %b/%h/%b/%h want 1/12345678/0/0",
                               m1_done, m1_dout, m0_done, m0_dout); end
    m1_req = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] exp_addr;
    logic          exp_m1;
    apply_reset();
    m0_req = 1'b1; m0_r0w1 = 1'b0; m0_addr = 32'h100;
    m1_req = 1'b1; m1_r0w1 = 1'b0; m1_addr = 32'h200;
    for (int i = 0; i < 4; i++) begin
      exp_m1   = i[0];
      exp_addr = exp_m1 ? 32'h200 : 32'h100;
      tick();
      checks++; if (c_en !== 1'b1 || c_addr !== exp_addr)
        begin errors++; $display("FAIL rr_gnt%0d got en=%b addr=%h want 1/%h", i, c_en, c_addr, exp_addr); end
      c_rdy = 1'b1; c_dout = 32'hc0de_0000 + i;
      tick();
      c_rdy = 1'b0;
      checks++; if (m0_done !== !exp_m1 || m1_done !== exp_m1)
        begin errors++; $display("FAIL rr_done%0d got %b%b want %b%b", i, m1_done, m0_done,
                                 exp_m1, !exp_m1); end
      tick();
    end
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_busy();
    apply_reset();
    m1_req = 1'b1; m1_r0w1 = 1'b0; m1_addr = 32'h40;
    tick();
    checks++; if (busy !== 1'b1 || c_en !== 1'b1)
      begin errors++; $display("FAIL rb_busy got busy=%b en=%b want 1/1", busy, c_en); end
    rst = 1'b0; c_rdy = 1'b1; c_dout = 32'h7777_7777;
    tick();
    checks++; if (c_en !== 1'b0 || busy !== 1'b0 || m1_done !== 1'b0 || arb_err !== 1'b0)
      begin errors++; $display("FAIL rb_abort got en=%b busy=%b done=%b err=%b want 0000",
                               c_en, busy, m1_done, arb_err); end
    rst = 1'b1;
    tick();
    checks++; if (c_en !== 1'b1 || m1_done !== 1'b0 || c_addr !== 32'h40)
      begin errors++; $display("FAIL rb_restart got en=%b done=%b addr=%h want 1/0/40",
                               c_en, m1_done, c_addr); end
    tick();
    c_rdy = 1'b0;
    checks++; if (m1_done !== 1'b1 || m1_dout !== 32'h7777_7777)
      begin errors++; $display("FAIL rb_done got %b/%h want 1/77777777", m1_done, m1_dout); end
    m1_req = 1'b0;
    tick();
  endtask

`ifdef CACHE_ARB_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    m1_req = 1'b1; m1_r0w1 = 1'b0; m1_addr = 32'h84; c_rdy = 1'b0; c_dout = 32'hffff_ffff;
    tick();
    for (int i = 0; i < 7; i++) tick();
    checks++; if (busy !== 1'b1 || m1_done !== 1'b0 || arb_err !== 1'b0)
      begin errors++; $display("FAIL to_wait got busy=%b done=%b err=%b want 1/0/0", busy, m1_done, arb_err); end
    tick();
    checks++; if (m1_done !== 1'b1 || arb_err !== 1'b1 || m1_dout !== 32'h0 || c_en !== 1'b0)
      begin errors++; $display("FAIL to_fire got done=%b err=%b dout=%h en=%b want 1/1/0/0",
                               m1_done, arb_err, m1_dout, c_en); end
    m1_req = 1'b0;
    tick();
    checks++; if (arb_err !== 1'b0 || m1_done !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL to_idle got err=%b done=%b busy=%b want 000", arb_err, m1_done, busy); end
  endtask
`else
  task automatic test_no_timeout();
    apply_reset();
    m1_req = 1'b1; m1_r0w1 = 1'b0; m1_addr = 32'h84; c_rdy = 1'b0;
    tick();
    for (int i = 0; i < 300; i++) tick();
    checks++; if (busy !== 1'b1 || c_en !== 1'b1 || m1_done !== 1'b0 || arb_err !== 1'b0)
      begin errors++; $display("FAIL nto_wait got busy=%b en=%b done=%b err=%b want 1/1/0/0",
                               busy, c_en, m1_done, arb_err); end
    c_rdy = 1'b1; c_dout = 32'h0bad_cafe;
    tick();
    c_rdy = 1'b0;
    checks++; if (m1_done !== 1'b1 || m1_dout !== 32'h0bad_cafe || arb_err !== 1'b0)
      begin errors++; $display("FAIL nto_done got %b/%h/%b want 1/0badcafe/0", m1_done, m1_dout, arb_err); end
    m1_req = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_back_to_back();
    test_round_robin();
    test_reset_busy();
`ifdef CACHE_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
